// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory for the IF stage: a valid/ready stream fills words
// from index 0, then PC-addressed fetches are served with one cycle of latency.
module instr_mem_loadable #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 64,
    parameter int                BYTE_ADDR = 1,
    parameter logic [DATA_W-1:0] NOP_WORD  = {DATA_W{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       ld_last,
    input  logic                       reload,
    input  logic                       fetch_en,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          fetch_addr,
    output logic [DATA_W-1:0]          instr,
    output logic                       instr_valid,
    output logic                       addr_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] loaded_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = ADDR_W - BYTE_ADDR;

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              addr_err_q, addr_err_d;
    logic              instr_sel_q, instr_sel_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [IW-1:0]     idx;
    logic [AW-1:0]     rd_addr;
    logic              misaligned;
    logic              out_of_range;
    logic              ld_fire;
    logic              rd_en;

    assign idx          = fetch_addr[ADDR_W-1:BYTE_ADDR];
    assign rd_addr      = idx[AW-1:0];
    assign out_of_range = 32'(idx) >= 32'(wr_ptr_q);
    assign ld_fire      = ld_valid && (state_q == ST_LOAD);

    generate
        if (BYTE_ADDR > 0) begin : g_align
            assign misaligned = |fetch_addr[BYTE_ADDR-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        instr_valid_d = instr_valid_q;
        addr_err_d    = addr_err_q;
        instr_sel_d   = instr_sel_q;
        rd_en         = 1'b0;
        case (state_q)
            ST_LOAD: begin
                instr_valid_d = 1'b0;
                addr_err_d    = 1'b0;
                instr_sel_d   = 1'b0;
                if (ld_fire) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (ld_last || (wr_ptr_q == CW'(DEPTH - 1))) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_d       = ST_LOAD;
                    wr_ptr_d      = '0;
                    instr_valid_d = 1'b0;
                    addr_err_d    = 1'b0;
                    instr_sel_d   = 1'b0;
                end else if (flush) begin
                    instr_valid_d = 1'b0;
                    addr_err_d    = 1'b0;
                    instr_sel_d   = 1'b0;
                end else if (stall) begin
                    instr_valid_d = instr_valid_q;
                end else if (fetch_en) begin
                    if (misaligned || out_of_range) begin
                        instr_valid_d = 1'b0;
                        addr_err_d    = 1'b1;
                        instr_sel_d   = 1'b0;
                    end else begin
                        instr_valid_d = 1'b1;
                        addr_err_d    = 1'b0;
                        instr_sel_d   = 1'b1;
                        rd_en         = 1'b1;
                    end
                end else begin
                    // Idle cycle: instr and addr_err keep their last values.
                    instr_valid_d = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOAD;
            wr_ptr_q      <= '0;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            instr_sel_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            instr_valid_q <= instr_valid_d;
            addr_err_q    <= addr_err_d;
            instr_sel_q   <= instr_sel_d;
        end
    end

    // Storage and read register carry no reset so they map onto block RAM.
    // The read register only advances on an accepted fetch, which gives stall-hold for free.
    always_ff @(posedge clk) begin
        if (ld_fire && !rst) begin
            mem[wr_ptr_q[AW-1:0]] <= ld_data;
        end
        if (rd_en && !rst) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign instr        = instr_sel_q ? rd_data_q : NOP_WORD;
    assign instr_valid  = instr_valid_q;
    assign addr_err     = addr_err_q;
    assign busy         = (state_q == ST_LOAD);
    assign ld_ready     = (state_q == ST_LOAD);
    assign loaded_count = wr_ptr_q;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: directed program/fetch sequences with literal checks,
// then random traffic compared every cycle against a behavioural model.
module tb_instr_mem_loadable;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_last = 1'b0;
    logic              reload = 1'b0;
    logic              fetch_en = 1'b0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              addr_err;
    logic              busy;
    logic [CW-1:0]     loaded_count;

    int tests = 0;
    int fails = 0;

    instr_mem_loadable #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BYTE_ADDR(1), .NOP_WORD(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ld_last(ld_last), .reload(reload), .fetch_en(fetch_en), .stall(stall), .flush(flush),
        .fetch_addr(fetch_addr), .instr(instr), .instr_valid(instr_valid), .addr_err(addr_err),
        .busy(busy), .loaded_count(loaded_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: program image, loaded word count and the visible fetch result.
    int  m_mem [DEPTH];
    bit  m_ok = 0;
    bit  m_loading;
    int  m_count;
    int  m_instr;
    bit  m_valid;
    bit  m_err;

    always @(posedge clk) begin
        int a;
        if (rst) begin
            m_ok = 1; m_loading = 1; m_count = 0; m_instr = 0; m_valid = 0; m_err = 0;
        end else if (m_ok) begin
            if (m_loading) begin
                if (ld_valid) begin
                    m_mem[m_count] = int'(ld_data);
                    m_count++;
                    if (ld_last || m_count == DEPTH) m_loading = 0;
                end
            end else if (reload) begin
                m_loading = 1; m_count = 0; m_instr = 0; m_valid = 0; m_err = 0;
            end else if (flush) begin
                m_instr = 0; m_valid = 0; m_err = 0;
            end else if (stall) begin
                // outputs unchanged
            end else if (fetch_en) begin
                a = int'(fetch_addr);
                if ((a % 2) != 0 || (a / 2) >= m_count) begin
                    m_instr = 0; m_valid = 0; m_err = 1;
                end else begin
                    m_instr = m_mem[a / 2]; m_valid = 1; m_err = 0;
                end
            end else begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("instr", int'(instr), m_instr);
            check("instr_valid", int'(instr_valid), int'(m_valid));
            check("addr_err", int'(addr_err), int'(m_err));
            check("busy", int'(busy), int'(m_loading));
            check("ld_ready", int'(ld_ready), int'(m_loading));
            check("loaded_count", int'(loaded_count), m_count);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid = 0; ld_last = 0; reload = 0; fetch_en = 0; stall = 0; flush = 0;
    endtask

    task automatic fetch(input int pc);
        fetch_en = 1; fetch_addr = ADDR_W'(pc);
        step();
    endtask

    task automatic do_reload();
        idle_inputs();
        reload = 1;
        step();
        reload = 0;
    endtask

    logic [DATA_W-1:0] prog [4] = '{16'h1010, 16'h1231, 16'h145e, 16'h167f};

    initial begin
        rst = 1;
        step(); step();
        check("rst_busy", int'(busy), 1);
        check("rst_ld_ready", int'(ld_ready), 1);
        check("rst_count", int'(loaded_count), 0);
        check("rst_valid", int'(instr_valid), 0);
        check("rst_instr", int'(instr), 0);
        rst = 0;

        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_data = prog[i]; ld_last = (i == 3);
            step();
            if (i < 3) check("load_ready_mid", int'(ld_ready), 1);
        end
        idle_inputs();
        check("load_count", int'(loaded_count), 4);
        check("load_busy", int'(busy), 0);
        check("load_ready_done", int'(ld_ready), 0);

        for (int i = 0; i < 4; i++) begin
            fetch(2 * i);
            check("fetch_instr", int'(instr), int'(prog[i]));
            check("fetch_valid", int'(instr_valid), 1);
            check("fetch_err", int'(addr_err), 0);
        end
        fetch(3);
        check("misalign_err", int'(addr_err), 1);
        check("misalign_valid", int'(instr_valid), 0);
        check("misalign_instr", int'(instr), 0);
        fetch(8);
        check("range_err", int'(addr_err), 1);
        check("range_instr", int'(instr), 0);

        fetch(2);
        stall = 1; fetch_addr = 4;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", int'(instr), 16'h1231);
            check("stall_valid", int'(instr_valid), 1);
        end
        flush = 1;
        step();
        check("flush_instr", int'(instr), 0);
        check("flush_valid", int'(instr_valid), 0);
        idle_inputs();
        step();

        fetch_en = 1; fetch_addr = 0; reload = 1;
        step();
        check("reload_busy", int'(busy), 1);
        check("reload_valid", int'(instr_valid), 0);
        check("reload_count", int'(loaded_count), 0);
        idle_inputs();

        // Backpressure: beats with ld_valid low (even carrying ld_last) are not taken.
        for (int i = 0; i < 6; i++) begin
            ld_valid = (i % 2 == 0); ld_data = DATA_W'(16'hA000 + i); ld_last = (i == 3 || i == 4);
            step();
        end
        idle_inputs();
        check("bp_count", int'(loaded_count), 3);
        check("bp_busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            fetch(2 * i);
            check("bp_instr", int'(instr), 16'hA000 + 2 * i);
        end

        do_reload();
        for (int i = 0; i < DEPTH + 1; i++) begin
            ld_valid = 1; ld_data = DATA_W'(16'hB000 + i); ld_last = 0;
            step();
        end
        idle_inputs();
        check("full_count", int'(loaded_count), DEPTH);
        check("full_busy", int'(busy), 0);
        fetch(2 * (DEPTH - 1));
        check("full_last_word", int'(instr), 16'hB000 + DEPTH - 1);

        do_reload();
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1; ld_data = DATA_W'(16'hC000 + i);
            step();
        end
        rst = 1; idle_inputs();
        step();
        rst = 0;
        check("midrst_count", int'(loaded_count), 0);
        check("midrst_busy", int'(busy), 1);
        check("midrst_ready", int'(ld_ready), 1);
        check("midrst_valid", int'(instr_valid), 0);

        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            ld_valid   = ($urandom_range(0, 9) < 7);
            ld_data    = DATA_W'($urandom);
            ld_last    = ($urandom_range(0, 9) < 2);
            reload     = ($urandom_range(0, 39) == 0);
            fetch_en   = ($urandom_range(0, 9) < 7);
            stall      = ($urandom_range(0, 9) < 2);
            flush      = ($urandom_range(0, 9) == 0);
            fetch_addr = ADDR_W'($urandom_range(0, 2 * DEPTH + 3));
            step();
        end
        rst = 0; idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
